// File: rtl/ddp_result_receiver_if.sv
// Bundle of DDP-side Send/Ack packet signals and host-side valid/ready packet view.
// The slave modport is the receiver; the master modport is the DDP plus host logic.
interface ddp_result_receiver_if;
    logic        Send_in;
    logic [37:0] PACKET_IN;
    logic        Ack_out;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [37:0] PKT;
    logic [6:0]  PKT_NODE;
    logic        PKT_LR;
    logic        PKT_JOIN;
    logic [15:0] PKT_DATA;

    modport slave (
        input  Send_in, PACKET_IN, pkt_ready,
        output Ack_out, pkt_valid, PKT, PKT_NODE, PKT_LR, PKT_JOIN, PKT_DATA
    );

    modport master (
        output Send_in, PACKET_IN, pkt_ready,
        input  Ack_out, pkt_valid, PKT, PKT_NODE, PKT_LR, PKT_JOIN, PKT_DATA
    );
endinterface

// File: rtl/ddp_result_receiver.sv
// Receives DDP result packets over the bundled-data Send/Ack channel, buffers them
// in a small FIFO and presents the head with decoded fields on a valid/ready port.
module ddp_result_receiver #(
    parameter int DEPTH = 4,
    parameter int ACK_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 MR,
    ddp_result_receiver_if.slave bus,
    output logic [CNT_W-1:0]     rx_count,
    output logic [7:0]           hdr_err,
    output logic [1:0]           state_dbg
);
    // Handshakes: DDP side is 4-phase, active-low: Send_in falls with PACKET_IN stable,
    // Ack_out pulses low for ACK_W cycles once the packet is taken, then Send_in must
    // return high before another capture. Host side: the head moves on pkt_valid && pkt_ready.
    localparam int AW     = $clog2(DEPTH);
    localparam int ACK_CW = $clog2(ACK_W + 1);
    localparam logic [AW:0]       FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]       CNT_ONE  = (AW + 1)'(1);
    localparam logic [ACK_CW-1:0] ACK_LOAD = ACK_CW'(ACK_W);
    localparam logic [ACK_CW-1:0] ACK_ONE  = ACK_CW'(1);

    typedef enum logic [1:0] {
        WAIT_REQ = 2'd0,
        ACK      = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t            state;
    logic              ack;
    logic [ACK_CW-1:0] ack_cnt;
    logic              send_meta;
    logic              s_send;

    logic [37:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_next;
    logic              full;
    logic              empty;
    logic [37:0]       head;

    logic              capture;
    logic              hdr_ok;
    logic              wr_en;
    logic              rd_en;

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            send_meta <= 1'b1;
            s_send    <= 1'b1;
        end else begin
            send_meta <= bus.Send_in;
            s_send    <= send_meta;
        end
    end

    // Full is the registered pre-edge value, so a same-cycle read never admits a capture.
    assign capture = (state == WAIT_REQ) && !s_send && !full;
    assign hdr_ok  = (bus.PACKET_IN[37:35] == 3'b111);
    assign wr_en   = capture && hdr_ok;
    assign rd_en   = !empty && bus.pkt_ready;

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            state   <= WAIT_REQ;
            ack     <= 1'b1;
            ack_cnt <= '0;
        end else begin
            case (state)
                WAIT_REQ: begin
                    if (capture) begin
                        ack     <= 1'b0;
                        ack_cnt <= ACK_LOAD;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    if (ack_cnt <= ACK_ONE) begin
                        ack   <= 1'b1;
                        state <= WAIT_REL;
                    end else begin
                        ack_cnt <= ack_cnt - ACK_ONE;
                    end
                end
                WAIT_REL: begin
                    if (s_send) state <= WAIT_REQ;
                end
                default: begin
                    ack   <= 1'b1;
                    state <= WAIT_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            rx_count <= '0;
            hdr_err  <= '0;
        end else begin
            if (wr_en) rx_count <= rx_count + CNT_W'(1);
            if (capture && !hdr_ok && hdr_err != 8'hFF) hdr_err <= hdr_err + 8'd1;
        end
    end

    always_comb begin
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= bus.PACKET_IN;
    end

    assign head          = empty ? 38'd0 : mem[rd_ptr];
    assign bus.Ack_out   = ack;
    assign bus.pkt_valid = !empty;
    assign bus.PKT       = head;
    assign bus.PKT_NODE  = head[26:20];
    assign bus.PKT_LR    = head[19];
    assign bus.PKT_JOIN  = head[18];
    assign bus.PKT_DATA  = head[15:0];
    assign state_dbg     = state;
endmodule

// File: tb/tb_ddp_result_receiver.sv
// Directed bench for ddp_result_receiver: Send/Ack driver, host-side scoreboard and
// checks of latency, back-pressure, header drops, stuck Send_in and mid-pulse reset.
module tb_ddp_result_receiver;
    localparam int DEPTH = 4;
    localparam int ACK_W = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             mr;
    logic [CNT_W-1:0] rx_count;
    logic [7:0]       hdr_err;
    logic [1:0]       state_dbg;

    logic [37:0] exp_q[$];
    int          passed = 0;
    int          total  = 0;
    int          rx_exp = 0;
    int          err_exp = 0;

    ddp_result_receiver_if bus ();

    ddp_result_receiver #(.DEPTH(DEPTH), .ACK_W(ACK_W), .CNT_W(CNT_W)) dut (
        .CLK       (clk),
        .MR        (mr),
        .bus       (bus),
        .rx_count  (rx_count),
        .hdr_err   (hdr_err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk(input logic [2:0] hdr, input logic [6:0] node,
                                       input logic lr, input logic [15:0] data);
        return {hdr, 8'd0, node, lr, 1'b0, 2'b00, data};
    endfunction

    // Scoreboard side: whatever the host consumes must match the oldest accepted packet.
    always @(negedge clk) begin
        logic [37:0] exp;
        if (!mr && bus.pkt_valid === 1'b1 && bus.pkt_ready === 1'b1) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check("head_pkt", bus.PKT, exp);
            check("head_node", bus.PKT_NODE, exp[26:20]);
            check("head_lr", bus.PKT_LR, exp[19]);
            check("head_data", bus.PKT_DATA, exp[15:0]);
        end
    end

    task automatic model_accept(input logic [37:0] p);
        if (p[37:35] == 3'b111) begin
            exp_q.push_back(p);
            rx_exp++;
        end else if (err_exp < 255) begin
            err_exp++;
        end
    endtask

    task automatic send_pkt(input logic [37:0] p);
        int n;
        bus.PACKET_IN = p;
        bus.Send_in   = 1'b0;
        model_accept(p);
        n = 0;
        while (bus.Ack_out !== 1'b0 && n < 20) begin tick(); n++; end
        check("ack_latency", n, 3);
        n = 0;
        while (bus.Ack_out !== 1'b1 && n < 20) begin tick(); n++; end
        check("ack_width", n, ACK_W);
        bus.Send_in = 1'b1;
        repeat (3) tick();
    endtask

    task automatic drain();
        int n;
        bus.pkt_ready = 1'b1;
        n = 0;
        while (bus.pkt_valid === 1'b1 && n < 30) begin tick(); n++; end
        check("drain_bounded", (n < 30), 1);
        check("queue_empty", exp_q.size(), 0);
        bus.pkt_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [37:0] p;
        int n;
        int pulses;
        int held_bad;
        logic prev;

        mr = 1'b1;
        bus.Send_in   = 1'b1;
        bus.PACKET_IN = '0;
        bus.pkt_ready = 1'b0;
        repeat (3) tick();
        check("rst_ack", bus.Ack_out, 1);
        check("rst_valid", bus.pkt_valid, 0);
        check("rst_pkt", bus.PKT, 0);
        check("rst_rx", rx_count, 0);
        check("rst_hdr", hdr_err, 0);
        check("rst_state", state_dbg, 0);
        mr = 1'b0;
        repeat (2) tick();

        // Single packet, edge-accurate Ack timing, host not ready.
        p = mk(3'b111, 7'd10, 1'b0, 16'd5);
        bus.PACKET_IN = p;
        bus.Send_in   = 1'b0;
        model_accept(p);
        tick(); check("t1_ack_e1", bus.Ack_out, 1);
        tick(); check("t1_ack_e2", bus.Ack_out, 1);
        tick(); check("t1_ack_e3", bus.Ack_out, 0);
        check("t1_valid_e3", bus.pkt_valid, 1);
        tick(); check("t1_ack_e4", bus.Ack_out, 0);
        tick(); check("t1_ack_e5", bus.Ack_out, 1);
        bus.Send_in = 1'b1;
        check("t1_node", bus.PKT_NODE, 10);
        check("t1_data", bus.PKT_DATA, 5);
        check("t1_lr", bus.PKT_LR, 0);
        check("t1_join", bus.PKT_JOIN, 0);
        check("t1_rx", rx_count, rx_exp);
        repeat (3) tick();
        drain();

        // Four packets streamed to a ready host.
        bus.pkt_ready = 1'b1;
        send_pkt(mk(3'b111, 7'd1, 1'b0, 16'd4));
        send_pkt(mk(3'b111, 7'd2, 1'b0, 16'd2));
        send_pkt(mk(3'b111, 7'd1, 1'b1, 16'd8));
        send_pkt(mk(3'b111, 7'd2, 1'b1, 16'd3));
        repeat (2) tick();
        check("t2_rx", rx_count, rx_exp);
        check("t2_hdr", hdr_err, err_exp);
        drain();

        // Back-pressure: fill the FIFO, the fifth packet must wait for a host read.
        for (int i = 0; i < DEPTH; i++) send_pkt(mk(3'b111, 7'(i), 1'b0, 16'(100 + i)));
        check("bp_valid", bus.pkt_valid, 1);
        check("bp_head", bus.PKT_DATA, 100);
        p = mk(3'b111, 7'd9, 1'b1, 16'd200);
        bus.PACKET_IN = p;
        bus.Send_in   = 1'b0;
        model_accept(p);
        held_bad = 0;
        repeat (10) begin tick(); if (bus.Ack_out !== 1'b1) held_bad++; end
        check("bp_ack_held", held_bad, 0);
        check("bp_state", state_dbg, 0);
        bus.pkt_ready = 1'b1;
        tick();
        bus.pkt_ready = 1'b0;
        check("bp_ack_read_edge", bus.Ack_out, 1);
        tick();
        check("bp_ack_next_edge", bus.Ack_out, 0);
        n = 0;
        while (bus.Ack_out !== 1'b1 && n < 20) begin tick(); n++; end
        check("bp_ack_width", n, ACK_W);
        bus.Send_in = 1'b1;
        repeat (3) tick();
        check("bp_head_after", bus.PKT_DATA, 101);
        check("bp_rx", rx_count, rx_exp);
        drain();

        // Bad header: acknowledged but dropped.
        send_pkt(mk(3'b011, 7'd5, 1'b0, 16'hBEEF));
        check("bad_valid", bus.pkt_valid, 0);
        check("bad_hdr", hdr_err, err_exp);
        check("bad_rx", rx_count, rx_exp);

        // Send_in stuck low: exactly one capture until it is released.
        p = mk(3'b111, 7'd33, 1'b0, 16'd77);
        bus.PACKET_IN = p;
        bus.Send_in   = 1'b0;
        model_accept(p);
        pulses = 0;
        prev = 1'b1;
        repeat (20) begin
            tick();
            if (prev === 1'b1 && bus.Ack_out === 1'b0) pulses++;
            prev = bus.Ack_out;
        end
        check("stuck_pulses", pulses, 1);
        check("stuck_rx", rx_count, rx_exp);
        bus.Send_in = 1'b1;
        repeat (3) tick();
        send_pkt(mk(3'b111, 7'd34, 1'b1, 16'd78));
        check("stuck_next_rx", rx_count, rx_exp);
        drain();

        // Reset while Ack is low.
        p = mk(3'b111, 7'd50, 1'b0, 16'd900);
        bus.PACKET_IN = p;
        bus.Send_in   = 1'b0;
        model_accept(p);
        n = 0;
        while (bus.Ack_out !== 1'b0 && n < 20) begin tick(); n++; end
        check("mr_pre_lat", n, 3);
        #2;
        mr = 1'b1;
        #1;
        check("mr_ack", bus.Ack_out, 1);
        check("mr_valid", bus.pkt_valid, 0);
        check("mr_rx", rx_count, 0);
        check("mr_hdr", hdr_err, 0);
        check("mr_state", state_dbg, 0);
        exp_q.delete();
        rx_exp  = 0;
        err_exp = 0;
        bus.Send_in = 1'b1;
        repeat (2) tick();
        mr = 1'b0;
        repeat (2) tick();
        bus.pkt_ready = 1'b1;
        send_pkt(mk(3'b111, 7'd60, 1'b1, 16'd901));
        check("mr_after_rx", rx_count, 1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
